// File: rtl/run_ctrl_pkg.sv
// Shared types and default parameters for the core run controller.
package run_ctrl_pkg;

    localparam int CW_DEF         = 16;
    localparam int MAX_CYCLES_DEF = 1000;
    localparam int RST_CYCLES_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_TMO  = 3'd4
    } run_state_t;

    // States from which a host start launches a new run.
    function automatic logic is_launchable(input run_state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_TMO);
    endfunction

endpackage

// File: rtl/run_controller_cycle_counter.sv
// Saturating executed-cycle counter with terminal compare at MAX_CYCLES-1.
module cycle_counter #(
    parameter int CW         = 16,
    parameter int MAX_CYCLES = 1000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          at_term
);

    localparam logic [CW-1:0] TERM     = CW'(MAX_CYCLES - 1);
    localparam logic [CW-1:0] ALL_ONES = {CW{1'b1}};
    localparam logic [CW-1:0] ONE      = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] count_r;

    // Counter register: clear wins over increment, never wraps past all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
        end else if (clr) begin
            count_r <= {CW{1'b0}};
        end else if (inc && (count_r != ALL_ONES)) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count   = count_r;
    assign at_term = (count_r == TERM);

endmodule

// File: rtl/run_controller.sv
// Start/reset/enable lifecycle sequencer for the single-cycle core.
// Optional single-step support is compiled in with RUN_CTRL_STEP_EN.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int CW         = CW_DEF,
    parameter int MAX_CYCLES = MAX_CYCLES_DEF,
    parameter int RST_CYCLES = RST_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          core_done,
`ifdef RUN_CTRL_STEP_EN
    input  logic          step_mode,
    input  logic          step,
`endif
    output logic          core_reset,
    output logic          core_enable,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_count
);

    localparam int CLR_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(RST_CYCLES - 1);
    localparam logic [CLR_W-1:0] CLR_ONE  = {{(CLR_W-1){1'b0}}, 1'b1};

    run_state_t       state_r;
    run_state_t       state_next_s;
    logic [CLR_W-1:0] clr_cnt_r;
    logic             clr_last_s;
    logic             launch_s;
    logic             cnt_inc_s;
    logic             at_term_s;
    logic             step_ok_s;
    logic             core_reset_r;
    logic             core_enable_r;
    logic             busy_r;
    logic             done_r;
    logic             timeout_r;

`ifdef RUN_CTRL_STEP_EN
    assign step_ok_s = !step_mode || step;
`else
    assign step_ok_s = 1'b1;
`endif

    assign clr_last_s = (clr_cnt_r == CLR_LAST);
    // core_enable_r already folds in stepping, so it marks an executed cycle.
    assign cnt_inc_s  = (state_r == ST_RUN) && core_enable_r && !core_done;

    // Next-state decode; abort beats halt, halt beats the watchdog.
    always_comb begin
        state_next_s = state_r;
        launch_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE, ST_TMO: begin
                if (start) begin
                    state_next_s = ST_CLR;
                    launch_s     = 1'b1;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_CLR: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                end else if (clr_last_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_CLR;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                end else if (core_done) begin
                    state_next_s = ST_DONE;
                end else if (cnt_inc_s && at_term_s) begin
                    state_next_s = ST_TMO;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Core reset hold counter, restarted on every launch.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt_r <= {CLR_W{1'b0}};
        end else if (launch_s && is_launchable(state_r)) begin
            clr_cnt_r <= {CLR_W{1'b0}};
        end else if ((state_r == ST_CLR) && !clr_last_s) begin
            clr_cnt_r <= clr_cnt_r + CLR_ONE;
        end else begin
            clr_cnt_r <= clr_cnt_r;
        end
    end

    // Outputs are registered from the next state so they line up with state_r.
    always_ff @(posedge clk) begin
        if (reset) begin
            core_reset_r  <= 1'b1;
            core_enable_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            timeout_r     <= 1'b0;
        end else begin
            core_reset_r  <= (state_next_s != ST_RUN);
            core_enable_r <= (state_next_s == ST_RUN) && step_ok_s;
            busy_r        <= (state_next_s == ST_CLR) || (state_next_s == ST_RUN);
            done_r        <= (state_next_s == ST_DONE);
            timeout_r     <= (state_next_s == ST_TMO);
        end
    end

    cycle_counter #(
        .CW         (CW),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_cycle_counter (
        .clk     (clk),
        .reset   (reset),
        .clr     (launch_s),
        .inc     (cnt_inc_s),
        .count   (cycle_count),
        .at_term (at_term_s)
    );

    assign core_reset  = core_reset_r;
    assign core_enable = core_enable_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign timeout     = timeout_r;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench: one default instance plus a MAX_CYCLES=20 watchdog instance on shared inputs.
module tb_run_controller;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic        core_done;
    logic        step_mode;
    logic        step;

    logic        core_reset,  core_enable,  busy,  done,  timeout;
    logic [15:0] cycle_count;
    logic        w_core_reset, w_core_enable, w_busy, w_done, w_timeout;
    logic [15:0] w_cycle_count;

    int vectors;
    int miscompares;
    int en_cycles;

    run_controller u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .core_done   (core_done),
`ifdef RUN_CTRL_STEP_EN
        .step_mode   (step_mode),
        .step        (step),
`endif
        .core_reset  (core_reset),
        .core_enable (core_enable),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count)
    );

    run_controller #(.MAX_CYCLES(20)) u_wd (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .core_done   (core_done),
`ifdef RUN_CTRL_STEP_EN
        .step_mode   (step_mode),
        .step        (step),
`endif
        .core_reset  (w_core_reset),
        .core_enable (w_core_enable),
        .busy        (w_busy),
        .done        (w_done),
        .timeout     (w_timeout),
        .cycle_count (w_cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; en_cycles = 0;
        reset = 1'b1; start = 1'b0; abort = 1'b0; core_done = 1'b0;
        step_mode = 1'b0; step = 1'b0;

        repeat (3) tick();
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_enable",     32'(core_enable), 32'd0);
        check("rst_busy",       32'(busy), 32'd0);
        check("rst_done",       32'(done), 32'd0);
        check("rst_timeout",    32'(timeout), 32'd0);
        check("rst_count",      32'(cycle_count), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_hold_busy", 32'(busy), 32'd0);

        // Launch: two CLR cycles then RUN.
        start = 1'b1; tick(); start = 1'b0;
        check("clr1_busy",       32'(busy), 32'd1);
        check("clr1_core_reset", 32'(core_reset), 32'd1);
        check("clr1_enable",     32'(core_enable), 32'd0);
        tick();
        check("clr2_core_reset", 32'(core_reset), 32'd1);
        check("clr2_enable",     32'(core_enable), 32'd0);
        tick();
        check("run_enable",      32'(core_enable), 32'd1);
        check("run_core_reset",  32'(core_reset), 32'd0);
        check("run_count0",      32'(cycle_count), 32'd0);

        // Watchdog instance times out after its 20th enabled cycle.
        repeat (19) tick();
        check("wd_count19",   32'(w_cycle_count), 32'd19);
        check("wd_tmo_early", 32'(w_timeout), 32'd0);
        tick();
        check("wd_timeout",   32'(w_timeout), 32'd1);
        check("wd_count20",   32'(w_cycle_count), 32'd20);
        check("wd_busy",      32'(w_busy), 32'd0);
        check("wd_core_rst",  32'(w_core_reset), 32'd1);
        check("dut_count20",  32'(cycle_count), 32'd20);

        repeat (120) tick();
        check("count140",     32'(cycle_count), 32'd140);
        check("not_done_yet", 32'(done), 32'd0);
        core_done = 1'b1; tick(); core_done = 1'b0;
        check("done",         32'(done), 32'd1);
        check("done_count",   32'(cycle_count), 32'd140);
        check("done_busy",    32'(busy), 32'd0);
        check("done_core_rst",32'(core_reset), 32'd1);
        check("wd_tmo_hold",  32'(w_cycle_count), 32'd20);
        tick();
        check("done_hold",    32'(done), 32'd1);

        // Relaunch clears counts; start in RUN ignored; abort on third RUN cycle.
        start = 1'b1; tick(); start = 1'b0;
        check("wd_relaunch_count", 32'(w_cycle_count), 32'd0);
        check("wd_relaunch_tmo",   32'(w_timeout), 32'd0);
        check("wd_relaunch_busy",  32'(w_busy), 32'd1);
        check("relaunch_done",     32'(done), 32'd0);
        tick(); tick();
        check("run2_enable", 32'(core_enable), 32'd1);
        start = 1'b1; tick(); start = 1'b0;
        check("start_ign_count", 32'(cycle_count), 32'd1);
        check("start_ign_rst",   32'(core_reset), 32'd0);
        tick();
        check("run3_count", 32'(cycle_count), 32'd2);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_busy",    32'(busy), 32'd0);
        check("abort_done",    32'(done), 32'd0);
        check("abort_timeout", 32'(timeout), 32'd0);
        check("abort_core_rst",32'(core_reset), 32'd1);
        check("abort_enable",  32'(core_enable), 32'd0);

        // Abort during CLR.
        start = 1'b1; tick(); start = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        check("clr_abort_busy",    32'(busy), 32'd0);
        check("clr_abort_core_rst",32'(core_reset), 32'd1);
        tick();
        check("clr_abort_enable",  32'(core_enable), 32'd0);
        check("clr_abort_idle",    32'(busy), 32'd0);

        // Minimum run: halt on the first RUN cycle.
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        core_done = 1'b1; tick(); core_done = 1'b0;
        check("min_done",  32'(done), 32'd1);
        check("min_count", 32'(cycle_count), 32'd0);
        check("min_busy",  32'(busy), 32'd0);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_in_done_ign", 32'(done), 32'd1);

        // Reset mid-run.
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick(); tick();
        check("pre_reset_count", 32'(cycle_count), 32'd2);
        reset = 1'b1; tick(); reset = 1'b0;
        check("midrst_count",   32'(cycle_count), 32'd0);
        check("midrst_busy",    32'(busy), 32'd0);
        check("midrst_core_rst",32'(core_reset), 32'd1);
        check("midrst_enable",  32'(core_enable), 32'd0);

`ifdef RUN_CTRL_STEP_EN
        // Single-step: three pulses four cycles apart.
        step_mode = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        check("step_idle_enable", 32'(core_enable), 32'd0);
        for (int p = 0; p < 3; p++) begin
            step = 1'b1; tick(); step = 1'b0;
            if (core_enable) en_cycles++;
            for (int q = 0; q < 3; q++) begin
                tick();
                if (core_enable) en_cycles++;
            end
        end
        check("step_enables", 32'(en_cycles), 32'd3);
        check("step_count",   32'(cycle_count), 32'd3);
        step_mode = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
